// File: rtl/he_stream_enc.sv
// Streaming Hamming SEC encoder with a 2-stage elastic pipeline,
// a one-shot single-bit error injector and an emitted-word counter.
module he_stream_enc #(
    parameter int K  = 8,
    parameter int CW = 16,
    localparam int M = (K == 1)   ? 2 :
                       (K <= 4)   ? 3 :
                       (K <= 11)  ? 4 :
                       (K <= 26)  ? 5 :
                       (K <= 57)  ? 6 :
                       (K <= 120) ? 7 :
                       (K <= 247) ? 8 :
                       (K <= 502) ? 9 :
                       (K <= 1013) ? 10 : 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [K-1:0]   din,
    input  logic           dvld,
    output logic           drdy,
    output logic [K+M-1:0] cout,
    output logic           cvld,
    input  logic           crdy,
    input  logic           inj_arm,
    input  logic [M-1:0]   inj_pos,
    output logic           inj_done,
    output logic [CW-1:0]  wcnt
);

    logic           r_s1_vld;
    logic [K-1:0]   r_s1_dat;
    logic           r_s1_tag;
    logic [M-1:0]   r_s1_pos;
    logic           r_arm;
    logic [M-1:0]   r_pos;
    logic           r_cvld;
    logic [K+M-1:0] r_cout;
    logic           r_otag;
    logic [CW-1:0]  r_wcnt;

    logic           w_out_adv;
    logic           w_in_xfer;
    logic           w_out_xfer;
    logic [M-1:0]   w_par;
    logic [K+M-1:0] w_cw;

    assign w_out_adv  = !r_cvld | crdy;
    assign drdy       = !r_s1_vld | w_out_adv;
    assign w_in_xfer  = dvld & drdy;
    assign w_out_xfer = r_cvld & crdy;

    assign cout     = r_cout;
    assign cvld     = r_cvld;
    assign wcnt     = r_wcnt;
    assign inj_done = w_out_xfer & r_otag;

    // Parity over S1 data, then optional single-bit flip of the codeword.
    // Data bit j sits at the (j+1)-th non-power-of-2 position >= 3.
    always_comb begin
        logic [31:0] w_q;
        w_par = '0;
        w_q   = 32'd2;
        for (int j = 0; j < K; j++) begin
            w_q = w_q + 32'd1;
            if ((w_q & (w_q - 32'd1)) == 32'd0)
                w_q = w_q + 32'd1;
            for (int p = 0; p < M; p++)
                if (w_q[p])
                    w_par[p] = w_par[p] ^ r_s1_dat[j];
        end
        w_cw = {w_par, r_s1_dat};
        for (int i = 0; i < K + M; i++)
            if (r_s1_tag && (int'(r_s1_pos) == i))
                w_cw[i] = ~w_cw[i];
    end

    // Injector arm flag: set by inj_arm, consumed by the next input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arm <= 1'b0;
            r_pos <= '0;
        end else if (w_in_xfer) begin
            r_arm <= 1'b0;
        end else if (inj_arm) begin
            r_arm <= 1'b1;
            r_pos <= inj_pos;
        end
    end

    // Stage 1: capture data and injection tag on input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
            r_s1_tag <= 1'b0;
            r_s1_pos <= '0;
        end else if (w_in_xfer) begin
            r_s1_vld <= 1'b1;
            r_s1_dat <= din;
            r_s1_tag <= r_arm | inj_arm;
            r_s1_pos <= inj_arm ? inj_pos : r_pos;
        end else if (w_out_adv) begin
            r_s1_vld <= 1'b0;
        end
    end

    // Stage 2: output register; cout holds its last value when draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cvld <= 1'b0;
            r_cout <= '0;
            r_otag <= 1'b0;
        end else if (w_out_adv) begin
            r_cvld <= r_s1_vld;
            if (r_s1_vld) begin
                r_cout <= w_cw;
                r_otag <= r_s1_tag;
            end else begin
                r_otag <= 1'b0;
            end
        end
    end

    // Count codewords accepted downstream, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst)
            r_wcnt <= '0;
        else if (w_out_xfer)
            r_wcnt <= r_wcnt + 1'b1;
    end

endmodule

// File: tb/tb_he_stream_enc.sv
// Directed self-checking bench for he_stream_enc (K=8, M=4).
// A second instance with CW=4 shares stimulus to check counter wrap.
module tb_he_stream_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        dvld;
    logic        drdy;
    logic [11:0] cout;
    logic        cvld;
    logic        crdy;
    logic        inj_arm;
    logic [3:0]  inj_pos;
    logic        inj_done;
    logic [15:0] wcnt;

    logic        drdy4;
    logic [11:0] cout4;
    logic        cvld4;
    logic        done4;
    logic [3:0]  wcnt4;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    he_stream_enc #(.K(8), .CW(16)) u_dut (
        .clk(clk), .rst(rst), .din(din), .dvld(dvld), .drdy(drdy),
        .cout(cout), .cvld(cvld), .crdy(crdy), .inj_arm(inj_arm),
        .inj_pos(inj_pos), .inj_done(inj_done), .wcnt(wcnt)
    );

    he_stream_enc #(.K(8), .CW(4)) u_w4 (
        .clk(clk), .rst(rst), .din(din), .dvld(dvld), .drdy(drdy4),
        .cout(cout4), .cvld(cvld4), .crdy(crdy), .inj_arm(inj_arm),
        .inj_pos(inj_pos), .inj_done(done4), .wcnt(wcnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] mpar(input logic [7:0] d);
        logic [3:0] pt [8];
        logic [3:0] r;
        pt = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12};
        r = 4'd0;
        for (int j = 0; j < 8; j++)
            if (d[j]) r = r ^ pt[j];
        return r;
    endfunction

    function automatic logic [7:0] mdec(input logic [11:0] c);
        logic [3:0] pt [8];
        logic [3:0] syn;
        logic [7:0] d;
        pt = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12};
        d = c[7:0];
        syn = c[11:8] ^ mpar(d);
        for (int j = 0; j < 8; j++)
            if (pt[j] == syn) d[j] = ~d[j];
        return d;
    endfunction

    logic [7:0]  bv [4];
    logic [11:0] be [4];
    logic [7:0]  rd;
    logic [11:0] ce;

    initial begin
        rst = 1'b1; din = '0; dvld = 1'b0; crdy = 1'b1;
        inj_arm = 1'b0; inj_pos = '0;
        bv = '{8'hA5, 8'h00, 8'h01, 8'hFF};
        be = '{12'h3A5, 12'h000, 12'h301, 12'h3FF};

        // reset state
        tick(); tick();
        chk("rst_cvld", 32'(cvld), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_wcnt", 32'(wcnt), 0);
        chk("rst_done", 32'(inj_done), 0);
        rst = 1'b0;
        #1;
        chk("rst_drdy", 32'(drdy), 1);

        // basic encode, back-to-back
        for (int i = 0; i < 4; i++) begin
            din = bv[i]; dvld = 1'b1;
            tick();
            if (i > 0) chk("enc", 32'(cout), 32'(be[i-1]));
        end
        dvld = 1'b0;
        tick();
        chk("enc_last", 32'(cout), 32'(be[3]));
        chk("enc_cvld", 32'(cvld), 1);
        tick();
        chk("drain_cvld", 32'(cvld), 0);
        chk("drain_cout", 32'(cout), 12'h3FF);
        chk("enc_wcnt", 32'(wcnt), 4);

        // backpressure
        crdy = 1'b0;
        din = 8'h10; dvld = 1'b1; #1;
        chk("bp_drdy0", 32'(drdy), 1);
        tick();
        din = 8'h80; #1;
        chk("bp_drdy1", 32'(drdy), 1);
        tick();
        din = 8'h3C; #1;
        chk("bp_drdy2", 32'(drdy), 0);
        tick();
        chk("bp_hold_v", 32'(cvld), 1);
        chk("bp_hold_c", 32'(cout), 12'h910);
        tick();
        chk("bp_hold_c2", 32'(cout), 12'h910);
        chk("bp_wcnt", 32'(wcnt), 4);
        crdy = 1'b1; #1;
        chk("bp_drdy3", 32'(drdy), 1);
        tick();
        dvld = 1'b0;
        chk("bp_w2", 32'(cout), 12'hC80);
        chk("bp_wcnt5", 32'(wcnt), 5);
        tick();
        chk("bp_w3", 32'(cout), 12'h23C);
        tick();
        chk("bp_end_v", 32'(cvld), 0);
        chk("bp_wcnt7", 32'(wcnt), 7);

        // injection: arm early, position captured at arm time
        inj_arm = 1'b1; inj_pos = 4'd2;
        tick();
        inj_arm = 1'b0; inj_pos = 4'd7;
        din = 8'hA5; dvld = 1'b1;
        tick();
        tick();
        dvld = 1'b0;
        chk("inj_cout", 32'(cout), 12'h3A1);
        chk("inj_done", 32'(inj_done), 1);
        tick();
        chk("inj_clean", 32'(cout), 12'h3A5);
        chk("inj_done0", 32'(inj_done), 0);
        tick();

        // re-arm updates position only
        inj_arm = 1'b1; inj_pos = 4'd3; tick();
        inj_pos = 4'd7; tick();
        inj_arm = 1'b0; inj_pos = 4'd0;
        din = 8'h00; dvld = 1'b1; tick();
        dvld = 1'b0; tick();
        chk("rearm", 32'(cout), 12'h080);
        tick();

        // decoder loopback, same-cycle arm, positions 0..11 plus out of range
        for (int p = 0; p < 14; p++) begin
            rd = 8'($urandom);
            din = rd; dvld = 1'b1;
            inj_arm = 1'b1; inj_pos = 4'(p);
            tick();
            inj_arm = 1'b0; dvld = 1'b0;
            tick();
            ce = {mpar(rd), rd};
            if (p < 12) ce[p] = ~ce[p];
            chk("lb_cw", 32'(cout), 32'(ce));
            chk("lb_dec", 32'(mdec(cout)), 32'(rd));
            chk("lb_done", 32'(inj_done), 1);
        end
        tick();

        // reset mid-stream with both stages full and armed
        crdy = 1'b0;
        din = 8'h11; dvld = 1'b1; tick();
        din = 8'h22; tick();
        dvld = 1'b0; inj_arm = 1'b1; inj_pos = 4'd0; tick();
        inj_arm = 1'b0;
        rst = 1'b1; tick();
        rst = 1'b0; #1;
        chk("mrst_cvld", 32'(cvld), 0);
        chk("mrst_wcnt", 32'(wcnt), 0);
        chk("mrst_drdy", 32'(drdy), 1);
        crdy = 1'b1;
        din = 8'h01; dvld = 1'b1; tick();
        dvld = 1'b0; tick();
        chk("mrst_clean", 32'(cout), 12'h301);
        tick();

        // counter wrap with CW=4
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            din = 8'(i); dvld = 1'b1;
            tick();
        end
        dvld = 1'b0;
        tick(); tick(); tick();
        chk("wrap_w4", 32'(wcnt4), 1);
        chk("wrap_w16", 32'(wcnt), 17);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
